if_stage: RTL

- Instruction-fetch stage directly upstream of the opcode decoder.
- Owns the PC and issues word reads to instruction memory over a req/ready + rvalid interface.
- Buffers returned instructions in a 2-entry FIFO and presents {pc, instr, opcode} to decode under a valid/ready handshake.
- Accepts redirects (exception, jump, branch) from the decode/control path, flushes wrong-path state and discards stale memory responses.

---
 rtl/if_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, imem reads, 2-entry fetch FIFO, redirect flush
module if_stage #(
   parameter logic [31:0] PC_RESET        = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR      = 32'h0000_0180,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        exc_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [5:0]  if_opcode,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   input  logic        id_ready
);

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [1:0]  outstanding, outstanding_nxt;
   logic [1:0]  fifo_count;
   logic [2:0]  credit_used;

   // PC of every accepted read, consumed in order as responses come back
   logic [31:0] tag_pc [2];
   logic        tag_wptr, tag_rptr;

   logic [31:0] fifo_pc    [2];
   logic [31:0] fifo_instr [2];
   logic        fifo_wptr, fifo_rptr;

   logic        redirect;
   logic [31:0] raw_target, target;
   logic        accept, resp, push, pop;

   // Redirect target selection: exception beats jump beats branch; low bits dropped
   always_comb begin
      redirect   = exc_i | jump_i | branch_i;
      raw_target = branch_target_i;
      if (exc_i)
         raw_target = EXC_VECTOR;
      else if (jump_i)
         raw_target = jump_target_i;
      target = raw_target & ~32'd3;
   end

   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
   assign accept      = imem_req & imem_ready;
   // A response with nothing outstanding (e.g. left over from before reset) is ignored
   assign resp        = imem_rvalid & (outstanding != 2'd0);
   assign push        = resp & (state == RUN) & ~redirect;
   assign pop         = if_valid & id_ready;

   assign imem_addr   = pc;
   assign if_valid    = (fifo_count != 2'd0);
   assign if_instr    = fifo_instr[fifo_rptr];
   assign if_pc       = fifo_pc[fifo_rptr];
   assign if_opcode   = if_instr[31:26];
   assign if_pc_plus4 = if_pc + 32'd4;

   // Outstanding-read count after this cycle's accept and response
   always_comb begin
      outstanding_nxt = outstanding;
      if (accept && !resp)
         outstanding_nxt = outstanding + 2'd1;
      else if (!accept && resp)
         outstanding_nxt = outstanding - 2'd1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= BOOT;
      else
         state <= state_nxt;
   end

   // FSM next state and request issue; stale reads after a redirect force DRAIN
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            imem_req = ~redirect && (credit_used < 3'(MAX_OUTSTANDING));
            if (redirect && outstanding_nxt != 2'd0)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (outstanding_nxt == 2'd0)
               state_nxt = RUN;
         end
         default: state_nxt = BOOT;
      endcase
   end

   // PC, outstanding count, tag queue and fetch FIFO updates
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= PC_RESET;
         outstanding <= 2'd0;
         tag_wptr    <= 1'b0;
         tag_rptr    <= 1'b0;
         fifo_count  <= 2'd0;
         fifo_wptr   <= 1'b0;
         fifo_rptr   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            tag_pc[i]     <= '0;
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else begin
         outstanding <= outstanding_nxt;
         if (accept) begin
            tag_pc[tag_wptr] <= pc;
            tag_wptr         <= ~tag_wptr;
         end
         if (resp)
            tag_rptr <= ~tag_rptr;
         if (redirect)
            pc <= target;
         else if (accept)
            pc <= pc + 32'd4;
         if (redirect) begin
            fifo_count <= 2'd0;
            fifo_wptr  <= 1'b0;
            fifo_rptr  <= 1'b0;
         end else begin
            if (push) begin
               fifo_pc[fifo_wptr]    <= tag_pc[tag_rptr];
               fifo_instr[fifo_wptr] <= imem_rdata;
               fifo_wptr             <= ~fifo_wptr;
            end
            if (pop)
               fifo_rptr <= ~fifo_rptr;
            case ({push, pop})
               2'b10:   fifo_count <= fifo_count + 2'd1;
               2'b01:   fifo_count <= fifo_count - 2'd1;
               default: fifo_count <= fifo_count;
            endcase
         end
      end
   end

   // Credit accounting must make a push into a full FIFO impossible
   assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && fifo_count == 2'd2));

endmodule
